// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor: opcodes,
// operand/address/instruction records, result width and executor FSM states.
package instr_register_pkg;

   localparam int unsigned DEPTH     = 32;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned OPERAND_W = 32;
   localparam int unsigned RESULT_W  = 2 * OPERAND_W;

   // Encodings 8..15 are undefined and execute as a zero result.
   typedef enum logic [3:0] {
      OP_ZERO  = 4'd0,
      OP_PASSA = 4'd1,
      OP_PASSB = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_MULT  = 4'd5,
      OP_DIV   = 4'd6,
      OP_MOD   = 4'd7
   } opcode_t;

   typedef logic signed [OPERAND_W-1:0] operand_t;
   typedef logic [ADDR_W-1:0]           address_t;

   typedef struct packed {
      opcode_t  opcode;
      operand_t operand_a;
      operand_t operand_b;
   } instruction_t;

   typedef logic signed [RESULT_W-1:0] result_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CAPTURE,
      ST_DIVIDE,
      ST_OUTPUT,
      ST_FINISH
   } exec_state_t;

   function automatic result_t sext(input operand_t v);
      return {{OPERAND_W{v[OPERAND_W-1]}}, v};
   endfunction

endpackage

// File: rtl/instr_executor_divider.sv
// Sequential restoring divider on operand magnitudes; signs are applied to the
// final quotient and remainder. done is high exactly W cycles after start.
module instr_seq_divider #(
   parameter int unsigned W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic signed [W-1:0]   dividend,
   input  logic signed [W-1:0]   divisor,
   output logic                  busy,
   output logic                  done,
   output logic signed [2*W-1:0] quotient,
   output logic signed [W-1:0]   remainder
);

   localparam int unsigned CW = $clog2(W);

   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic [W-1:0]  mag_a, mag_b;

   // One restoring step: returns {new remainder, new quotient shift register}.
   function automatic logic [2*W-1:0] step(input logic [W-1:0] rem,
                                           input logic [W-1:0] quo,
                                           input logic [W-1:0] dvs);
      logic [W:0] shifted;
      logic [W:0] diff;
      shifted = {rem, quo[W-1]};
      diff    = shifted - {1'b0, dvs};
      if (!diff[W]) begin
         return {diff[W-1:0], quo[W-2:0], 1'b1};
      end
      return {shifted[W-1:0], quo[W-2:0], 1'b0};
   endfunction

   always_comb begin
      mag_a  = dividend[W-1] ? W'(-dividend) : W'(dividend);
      mag_b  = divisor[W-1]  ? W'(-divisor)  : W'(divisor);
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      // The first step is folded into the start edge so done lands on cycle W.
      if (start) begin
         {rem_d, quo_d} = step('0, mag_a, mag_b);
         dvs_d  = mag_b;
         cnt_d  = CW'(W - 1);
         run_d  = 1'b1;
         qneg_d = dividend[W-1] ^ divisor[W-1];
         rneg_d = dividend[W-1];
      end else if (run_q) begin
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            {rem_d, quo_d} = step(rem_q, quo_q, dvs_q);
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end

   assign busy      = run_q;
   assign done      = run_q && (cnt_q == '0);
   assign quotient  = qneg_q ? -$signed({{W{1'b0}}, quo_q}) : $signed({{W{1'b0}}, quo_q});
   assign remainder = rneg_q ? -$signed(rem_q) : $signed(rem_q);

endmodule

// File: rtl/instr_executor.sv
// Walks a range of instruction-register entries, executes each opcode and
// presents tagged results on a valid/ready channel.
module instr_executor
   import instr_register_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES   = DEPTH,
   parameter int unsigned OPERAND_WIDTH = OPERAND_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic [ADDR_W-1:0] read_pointer,
   input  instruction_t      instruction_word,
   output logic              res_valid,
   input  logic              res_ready,
   output result_t           res_data,
   output logic [ADDR_W-1:0] res_addr,
   output opcode_t           res_opcode,
   output logic              res_div_zero,
   output logic              done
);

   exec_state_t       state_q, state_d;
   address_t          ptr_q, ptr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   result_t           res_data_q, res_data_d;
   address_t          res_addr_q, res_addr_d;
   opcode_t           res_opcode_q, res_opcode_d;
   logic              res_div_zero_q, res_div_zero_d;

   logic              div_start, div_busy, div_done;
   result_t           div_quotient;
   operand_t          div_remainder;
   result_t           op_a, op_b;
   address_t          ptr_next;

   instr_seq_divider #(
      .W (OPERAND_WIDTH)
   ) u_divider (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .dividend  (instruction_word.operand_a),
      .divisor   (instruction_word.operand_b),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quotient),
      .remainder (div_remainder)
   );

   assign op_a     = sext(instruction_word.operand_a);
   assign op_b     = sext(instruction_word.operand_b);
   assign ptr_next = (ptr_q == address_t'(NUM_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      remaining_d    = remaining_q;
      res_data_d     = res_data_q;
      res_addr_d     = res_addr_q;
      res_opcode_d   = res_opcode_q;
      res_div_zero_d = res_div_zero_q;
      div_start      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  ptr_d       = start_addr;
                  remaining_d = count;
                  state_d     = ST_FETCH;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FETCH: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            res_addr_d     = ptr_q;
            res_opcode_d   = instruction_word.opcode;
            res_div_zero_d = 1'b0;
            res_data_d     = '0;
            state_d        = ST_OUTPUT;
            case (instruction_word.opcode)
               OP_ZERO:  res_data_d = '0;
               OP_PASSA: res_data_d = op_a;
               OP_PASSB: res_data_d = op_b;
               OP_ADD:   res_data_d = op_a + op_b;
               OP_SUB:   res_data_d = op_a - op_b;
               OP_MULT:  res_data_d = op_a * op_b;
               OP_DIV, OP_MOD: begin
                  if (instruction_word.operand_b == '0) begin
                     res_div_zero_d = 1'b1;
                  end else begin
                     div_start = 1'b1;
                     state_d   = ST_DIVIDE;
                  end
               end
               default:  res_data_d = '0;
            endcase
         end
         ST_DIVIDE: begin
            if (div_busy && div_done) begin
               res_data_d = (res_opcode_q == OP_DIV) ? div_quotient : sext(div_remainder);
               state_d    = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (res_ready) begin
               remaining_d = remaining_q - 1'b1;
               ptr_d       = ptr_next;
               state_d     = (remaining_q == (ADDR_W + 1)'(1)) ? ST_FINISH : ST_FETCH;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ptr_q          <= '0;
         remaining_q    <= '0;
         res_data_q     <= '0;
         res_addr_q     <= '0;
         res_opcode_q   <= OP_ZERO;
         res_div_zero_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         remaining_q    <= remaining_d;
         res_data_q     <= res_data_d;
         res_addr_q     <= res_addr_d;
         res_opcode_q   <= res_opcode_d;
         res_div_zero_q <= res_div_zero_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign read_pointer = ptr_q;
   assign res_valid    = (state_q == ST_OUTPUT);
   assign res_data     = res_data_q;
   assign res_addr     = res_addr_q;
   assign res_opcode   = res_opcode_q;
   assign res_div_zero = res_div_zero_q;
   assign done         = (state_q == ST_FINISH);

endmodule

// File: doc/instr_executor.md
Name: instr_executor

Overview:
- Downstream consumer of the instruction register.
- On a start command it walks a range of register entries: drives read_pointer, captures instruction_word, and evaluates the opcode. ADD, SUB and MULT complete in a single cycle; DIV and MOD use an iterative divider.
- Each result is presented on a valid/ready output channel tagged with its source address.
- Sits between the instruction register and the result scoreboard/checker.

Parameters:
- NUM_ENTRIES, 32: instruction register depth; addresses wrap modulo NUM_ENTRIES.
- OPERAND_WIDTH, 32: signed operand width; result width is 2*OPERAND_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE, ignored otherwise.
- start_addr  input  5  first entry to execute.
- count  input  6  number of entries, 1..32; 0 gives an immediate done with no results.
- busy  output  1  high in every state except IDLE.
- read_pointer  output  5  address driven to the instruction register.
- instruction_word  input  instruction_t  register read data; valid one cycle after read_pointer.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  64  signed result.
- res_addr  output  5  source entry of res_data.
- res_opcode  output  opcode_t  opcode of the result.
- res_div_zero  output  1  DIV/MOD with operand_b == 0.
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, divider cleared. Reset overrides everything, including an in-flight run or a pending result; the pending result is discarded.
- FSM states: IDLE, FETCH, CAPTURE, DIVIDE, OUTPUT, FINISH.
- IDLE: on start with count != 0, latch start_addr into ptr and count into remaining, then go to FETCH. On start with count == 0, go to FINISH.
- FETCH: read_pointer = ptr; go to CAPTURE.
- CAPTURE: register instruction_word into instr.
  - For ZERO, PASSA, PASSB, ADD, SUB and MULT, compute the result and go to OUTPUT.
  - For DIV or MOD with operand_b == 0: result 0, res_div_zero = 1, go to OUTPUT.
  - For DIV or MOD otherwise: start the divider and go to DIVIDE.
- DIVIDE: wait for divider done (exactly OPERAND_WIDTH cycles after its start), then go to OUTPUT.
- OUTPUT: res_valid = 1, with res_data, res_addr, res_opcode and res_div_zero held stable until res_valid && res_ready.
  - On that handshake: remaining decrements and ptr increments modulo NUM_ENTRIES.
  - If remaining was 1, go to FINISH; otherwise go to FETCH.
- FINISH: done = 1 for one cycle, then IDLE. busy drops in the same cycle IDLE is entered.
- Latency for non-divide ops: start sampled at edge N; read_pointer valid in cycle N+1; res_valid is first asserted in cycle N+3. Minimum throughput is one result per 3 cycles.
- Latency for DIV/MOD: res_valid is asserted OPERAND_WIDTH cycles later than for non-divide ops.
- Arithmetic is on sign-extended 64-bit values:
  - ZERO = 0.
  - PASSA = sext(a); PASSB = sext(b).
  - ADD = a + b; SUB = a − b.
  - MULT = full 64-bit signed product.
  - DIV quotient truncates toward zero.
  - MOD remainder takes the sign of the dividend, matching SystemVerilog / and %.
- Undefined opcode: result 0, res_div_zero = 0.
- Address wrap: start_addr 30 with count 4 reads entries 30, 31, 0, 1.
- Back-pressure: OUTPUT may stall indefinitely; no further read is issued while stalled.

Decomposition:
- Shared package instr_register_pkg:
  - Existing types: opcode_t, operand_t, address_t, instruction_t.
  - Add result_t (logic signed [63:0]).
  - Add exec_state_t, the FSM enum.
- Sub-module instr_seq_divider:
  - Restoring divider on operand magnitudes; signs are fixed up at the end.
  - Ports: clk, reset, start, dividend, divisor, busy, done, quotient, remainder.
  - Exactly OPERAND_WIDTH cycles from start to done.

Test Plan:
- Entry 3 = {ADD, 5, −7}; start_addr 3, count 1, res_ready held 1:
  - res_valid in cycle N+3; res_data = −2, res_addr = 3.
  - done pulses one cycle after the handshake.
- Entries 30, 31, 0 = {MULT, 0x7FFFFFFF, 2}, {SUB, −5, 10}, {PASSB, 0, −1}; count 3:
  - read_pointer sequence 30, 31, 0.
  - Results 0xFFFFFFFE, −15, −1, with sign extension checked.
- Entry 0 = {DIV, −17, 5}, entry 1 = {MOD, −17, 5}:
  - Results −3 and −2.
  - Each res_valid 32 cycles later than the non-divide case.
- Entry 2 = {DIV, 9, 0}:
  - res_data = 0, res_div_zero = 1; the divider is not started.
- count 2, res_ready held 0 for 10 cycles after the first res_valid:
  - Result stable throughout; read_pointer not advanced.
  - Second result follows after ready goes high.
- reset asserted during DIVIDE, with start pulsed while busy:
  - Next cycle: all outputs 0, state IDLE.
  - The start pulsed while busy is ignored.
  - A subsequent start runs cleanly.
